// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with a registered grant index for decoder_2x4.
// Optional forced release of long-held grants is enabled with `define ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no live grant; arbitrate among req starting at ptr
// GRANT | gnt_idx owns the resource until done, req drop or hold timeout
module rr_arbiter_4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state, state_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic [1:0] gnt_idx_nxt;
  logic       gnt_valid_nxt;
  logic       timeout_nxt;
  logic [1:0] winner;
  logic       release_now;
  logic       hold_expired;

  // First set request at or after the pointer, wrapping modulo 4.
  function automatic logic [1:0] pick_winner(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] w;
    logic [1:0] c;
    w = p;
    for (int i = 3; i >= 0; i--) begin
      c = p + 2'(i);
      if (r[c]) w = c;
    end
    return w;
  endfunction

  assign winner      = pick_winner(req, ptr);
  assign release_now = done || !req[gnt_idx];

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD);

  logic [CW-1:0] hold_cnt;

  assign hold_expired = (state == GRANT) && (hold_cnt == CW'(MAX_HOLD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (state == GRANT && state_nxt == GRANT) begin
      hold_cnt <= hold_cnt + CW'(1);
    end else begin
      hold_cnt <= '0;
    end
  end
`else
  assign hold_expired = 1'b0;
`endif

  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    gnt_idx_nxt   = gnt_idx;
    gnt_valid_nxt = gnt_valid;
    timeout_nxt   = 1'b0;
    case (state)
      IDLE: begin
        gnt_valid_nxt = 1'b0;
        if (|req) begin
          state_nxt     = GRANT;
          gnt_idx_nxt   = winner;
          gnt_valid_nxt = 1'b1;
        end
      end
      GRANT: begin
        // A normal release on the last allowed cycle suppresses the timeout pulse.
        if (release_now || hold_expired) begin
          state_nxt     = IDLE;
          gnt_valid_nxt = 1'b0;
          ptr_nxt       = gnt_idx + 2'd1;
          timeout_nxt   = !release_now;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      gnt_idx   <= 2'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      gnt_idx   <= gnt_idx_nxt;
      gnt_valid <= gnt_valid_nxt;
      timeout   <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4: rotation, release paths, hold/timeout, async reset.
// Inputs change just after the falling edge; outputs are checked at the next falling edge.
module tb_rr_arbiter_4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;

  rr_arbiter_4 #(.MAX_HOLD(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [1:0] idx, input logic to);
    check_eq({tag, ".valid"},   32'(gnt_valid), 32'(v));
    check_eq({tag, ".idx"},     32'(gnt_idx),   32'(idx));
    check_eq({tag, ".timeout"}, 32'(timeout),   32'(to));
  endtask

  initial begin
    int hi_cnt;
    int to_cnt;
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    #3;
    expect_out("reset", 1'b0, 2'd0, 1'b0);
    tick();
    rst_n = 1'b1;

    // Idle with no requests
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_out("idle_noreq", 1'b0, 2'd0, 1'b0);
    end

    // All requesting: rotation 0,1,2,3 then wrap to 0
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      expect_out("rot_grant", 1'b1, 2'(k % 4), 1'b0);
      done = 1'b1;
      tick();
      expect_out("rot_gap", 1'b0, 2'(k % 4), 1'b0);
      done = 1'b0;
      if (k == 4) req = 4'b0000;
    end
    // ptr = 1
    req = 4'b0100;
    tick();
    expect_out("single2", 1'b1, 2'd2, 1'b0);
    done = 1'b1;
    tick();
    expect_out("single2_rel", 1'b0, 2'd2, 1'b0);
    done = 1'b0;
    req  = 4'b0101;
    tick();
    expect_out("ptr3_scan", 1'b1, 2'd0, 1'b0);
    req = 4'b0000;
    tick();
    expect_out("reqdrop0", 1'b0, 2'd0, 1'b0);

    // ptr = 1: grant 1, others toggling, then drop req[1] without done
    req = 4'b0010;
    tick();
    expect_out("grant1", 1'b1, 2'd1, 1'b0);
    req = 4'b1010;
    tick();
    expect_out("grant1_hold", 1'b1, 2'd1, 1'b0);
    req = 4'b1000;
    tick();
    expect_out("grant1_drop", 1'b0, 2'd1, 1'b0);
    req = 4'b0000;
    tick();
    expect_out("idle_after_drop", 1'b0, 2'd1, 1'b0);

    // done in IDLE is ignored; ptr = 2
    req  = 4'b0100;
    done = 1'b1;
    tick();
    expect_out("done_in_idle", 1'b1, 2'd2, 1'b0);
    tick();
    expect_out("done_rel", 1'b0, 2'd2, 1'b0);
    req  = 4'b0000;
    done = 1'b0;
    tick();

    // ptr = 3: requester 0 holds with no done
    req = 4'b0001;
    tick();
    expect_out("hold_grant", 1'b1, 2'd0, 1'b0);
`ifdef ARB_TIMEOUT_EN
    hi_cnt = 1;
    to_cnt = 0;
    for (int i = 0; i < 30 && gnt_valid; i++) begin
      tick();
      if (gnt_valid) hi_cnt++;
      if (timeout) to_cnt++;
    end
    check_eq("hold_len", 32'(hi_cnt), 32'd8);
    check_eq("to_pulse", 32'(timeout), 32'd1);
    check_eq("to_count", 32'(to_cnt), 32'd1);
    tick();
    expect_out("regrant", 1'b1, 2'd0, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    expect_out("last_cycle", 1'b1, 2'd0, 1'b0);
    done = 1'b1;
    tick();
    expect_out("done_beats_to", 1'b0, 2'd0, 1'b0);
    done = 1'b0;
    req  = 4'b0000;
    tick();
    expect_out("to_idle", 1'b0, 2'd0, 1'b0);
`else
    to_cnt = 0;
    for (int i = 0; i < 21; i++) begin
      tick();
      if (timeout) to_cnt++;
    end
    expect_out("hold_forever", 1'b1, 2'd0, 1'b0);
    check_eq("no_timeout", 32'(to_cnt), 32'd0);
    req = 4'b0000;
    tick();
    expect_out("hold_rel", 1'b0, 2'd0, 1'b0);
`endif

    // ptr = 1: move ptr to 2, then grant 3 and reset mid-grant
    req = 4'b0010;
    tick();
    expect_out("pre_rst_g1", 1'b1, 2'd1, 1'b0);
    req = 4'b0000;
    tick();
    req = 4'b1000;
    tick();
    expect_out("pre_rst_g3", 1'b1, 2'd3, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("async_rst", 1'b0, 2'd0, 1'b0);
    tick();
    rst_n = 1'b1;
    req   = 4'b0110;
    tick();
    expect_out("ptr_restart", 1'b1, 2'd1, 1'b0);
    req = 4'b0000;
    tick();
    req = 4'b1000;
    tick();
    expect_out("post_rst_g3", 1'b1, 2'd3, 1'b0);
    req = 4'b0000;
    tick();
    expect_out("final_rel", 1'b0, 2'd3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
